// File: rtl/jt12_pkg.sv
// Shared constants, types and helpers for the operator slot sequencer.
package jt12_pkg;

  localparam int SLOTS = 24;
  localparam int CHANS = 6;

  // Operator groups in slot order: each six-slot group holds one operator of every channel
  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S3 = 2'd1,
    OP_S2 = 2'd2,
    OP_S4 = 2'd3
  } op_grp_e;

  // Decoded channel field of the key register
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } ch_dec_t;

  // Key register bit for each operator group, packed LSB first: S1->4, S3->6, S2->5, S4->7
  localparam logic [11:0] OP_DIN_BIT = {3'd7, 3'd5, 3'd6, 3'd4};

  // Position of an operator group's flag inside the 4-bit mask taken from din[7:4]
  function automatic logic [1:0] op_mask_sel(input logic [1:0] grp);
    logic [2:0] dinBit;
    dinBit = OP_DIN_BIT[3*grp +: 3];
    return 2'(dinBit - 3'd4);
  endfunction

  // Channel codes 0..2 and 4..6 map onto indices 0..5; codes 3 and 7 are not channels
  function automatic ch_dec_t decode_ch(input logic [2:0] code);
    ch_dec_t dec;
    dec.valid = 1'b0;
    dec.idx   = 3'd0;
    case (code)
      3'd0, 3'd1, 3'd2: begin
        dec.valid = 1'b1;
        dec.idx   = code;
      end
      3'd4, 3'd5, 3'd6: begin
        dec.valid = 1'b1;
        dec.idx   = code - 3'd1;
      end
      default: begin
        dec.valid = 1'b0;
        dec.idx   = 3'd0;
      end
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/jt12_slot_cnt.sv
// Operator slot counter: walks slots 0..23 on clk_en and tracks the channel/operator
// group of the current slot, plus the slot about to be entered.
module jt12_slot_cnt
  import jt12_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_en_i,
  output logic [4:0] slot_o,
  output logic [2:0] ch_o,
  output logic [1:0] op_o,
  output logic       zero_o,
  output logic [4:0] next_slot_o,
  output logic [2:0] next_ch_o,
  output logic [1:0] next_op_o
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [2:0] LAST_CH   = 3'(CHANS - 1);

  logic [4:0] slot_q;
  logic [2:0] ch_q;
  logic [1:0] op_q;
  logic       zero_q;

  // Next slot position; channel and group step together so no divider is needed
  always_comb begin
    next_slot_o = (slot_q == LAST_SLOT) ? 5'd0 : slot_q + 5'd1;
    next_ch_o   = ch_q + 3'd1;
    next_op_o   = op_q;
    if (ch_q == LAST_CH) begin
      next_ch_o = 3'd0;
      next_op_o = op_q + 2'd1;
    end
  end

  // Advance the slot position on each enable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= 5'd0;
      ch_q   <= 3'd0;
      op_q   <= 2'd0;
      zero_q <= 1'b1;
    end else if (clk_en_i) begin
      slot_q <= next_slot_o;
      ch_q   <= next_ch_o;
      op_q   <= next_op_o;
      zero_q <= (next_slot_o == 5'd0);
    end
  end

  assign slot_o = slot_q;
  assign ch_o   = ch_q;
  assign op_o   = op_q;
  assign zero_o = zero_q;

endmodule

// File: rtl/jt12_kon_seq.sv
// Key-on sequencer: latches key register writes and applies them to each target
// slot as it is entered, producing per-slot key state and on/off events.
module jt12_kon_seq
  import jt12_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       up_keyon,
  input  logic [7:0] din,
  output logic [4:0] cur_slot,
  output logic [2:0] cur_ch,
  output logic [1:0] cur_op,
  output logic       zero,
  output logic       kon_state,
  output logic       keyon_ev,
  output logic       keyoff_ev
);

  localparam logic [4:0] LAST_VISIT = 5'(SLOTS - 1);

  logic [4:0] nextSlot;
  logic [2:0] nextCh;
  logic [1:0] nextOp;

  logic [3:0]  pendMask_q, pendMask_d;
  logic [2:0]  pendCh_q, pendCh_d;
  logic        pendVld_q, pendVld_d;
  logic [4:0]  visitCnt_q, visitCnt_d;
  logic [23:0] konVec_q, konVec_d;
  logic        konState_q, keyonEv_q, keyoffEv_q;
  logic        oldBit, newBit;
  ch_dec_t     wrDec;
  logic        unusedDin;

  jt12_slot_cnt u_slot_cnt (
    .clk_i       (clk),
    .rst_i       (rst),
    .clk_en_i    (clk_en),
    .slot_o      (cur_slot),
    .ch_o        (cur_ch),
    .op_o        (cur_op),
    .zero_o      (zero),
    .next_slot_o (nextSlot),
    .next_ch_o   (nextCh),
    .next_op_o   (nextOp)
  );

  assign wrDec = decode_ch(din[2:0]);

  // Bit 3 of the key register has no function
  assign unusedDin = din[3];

  // Pending write bookkeeping: retire after a full lap, a new write restarts the lap
  always_comb begin
    pendMask_d = pendMask_q;
    pendCh_d   = pendCh_q;
    pendVld_d  = pendVld_q;
    visitCnt_d = visitCnt_q;
    if (clk_en && pendVld_q) begin
      if (visitCnt_q == LAST_VISIT) begin
        pendVld_d  = 1'b0;
        visitCnt_d = 5'd0;
      end else begin
        visitCnt_d = visitCnt_q + 5'd1;
      end
    end
    if (up_keyon && wrDec.valid) begin
      pendMask_d = din[7:4];
      pendCh_d   = wrDec.idx;
      pendVld_d  = 1'b1;
      visitCnt_d = 5'd0;
    end
  end

  // New key state of the slot being entered, taken from the write pending before this edge
  always_comb begin
    konVec_d = konVec_q;
    oldBit   = konVec_q[nextSlot];
    newBit   = oldBit;
    if (pendVld_q && (nextCh == pendCh_q)) begin
      newBit = pendMask_q[op_mask_sel(nextOp)];
    end
    konVec_d[nextSlot] = newBit;
  end

  // Write latch runs on every clock edge, independent of the slot enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendMask_q <= 4'd0;
      pendCh_q   <= 3'd0;
      pendVld_q  <= 1'b0;
      visitCnt_q <= 5'd0;
    end else begin
      pendMask_q <= pendMask_d;
      pendCh_q   <= pendCh_d;
      pendVld_q  <= pendVld_d;
      visitCnt_q <= visitCnt_d;
    end
  end

  // Key state table and per-visit events move with the slot counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      konVec_q   <= 24'd0;
      konState_q <= 1'b0;
      keyonEv_q  <= 1'b0;
      keyoffEv_q <= 1'b0;
    end else if (clk_en) begin
      konVec_q   <= konVec_d;
      konState_q <= newBit;
      keyonEv_q  <= newBit & ~oldBit;
      keyoffEv_q <= ~newBit & oldBit;
    end
  end

  assign kon_state = konState_q;
  assign keyon_ev  = keyonEv_q;
  assign keyoff_ev = keyoffEv_q;

endmodule

// File: tb/tb_jt12_kon_seq.sv
// Directed bench for the key-on sequencer: slot walk, key writes, invalid codes,
// gapped and coincident writes, and asynchronous reset with a write pending.
module tb_jt12_kon_seq;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       up_keyon;
  logic [7:0] din;
  logic [4:0] cur_slot;
  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic       zero;
  logic       kon_state;
  logic       keyon_ev;
  logic       keyoff_ev;

  int nCompared;
  int nMismatched;
  int expSlot;

  localparam logic [23:0] CH0_MASK = 24'h041041;

  jt12_kon_seq dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .up_keyon  (up_keyon),
    .din       (din),
    .cur_slot  (cur_slot),
    .cur_ch    (cur_ch),
    .cur_op    (cur_op),
    .zero      (zero),
    .kon_state (kon_state),
    .keyon_ev  (keyon_ev),
    .keyoff_ev (keyoff_ev)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "[TB] timeout");
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock edge, then settle just after it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the slot the bench believes is current
  task automatic checkOutput(input logic expOn, input logic expOff, input logic expKon);
    check($sformatf("cur_slot@%0d", expSlot), 8'(cur_slot), 8'(expSlot));
    check($sformatf("cur_ch@%0d", expSlot), 8'(cur_ch), 8'(expSlot % 6));
    check($sformatf("cur_op@%0d", expSlot), 8'(cur_op), 8'(expSlot / 6));
    check($sformatf("zero@%0d", expSlot), 8'(zero), 8'(expSlot == 0));
    check($sformatf("keyon_ev@%0d", expSlot), 8'(keyon_ev), 8'(expOn));
    check($sformatf("keyoff_ev@%0d", expSlot), 8'(keyoff_ev), 8'(expOff));
    check($sformatf("kon_state@%0d", expSlot), 8'(kon_state), 8'(expKon));
  endtask

  // Single edge with the given inputs; the write strobe is dropped afterwards
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic en);
    up_keyon = wr;
    din      = data;
    clk_en   = en;
    tick();
    up_keyon = 1'b0;
    if (en) expSlot = (expSlot == 23) ? 0 : expSlot + 1;
  endtask

  // Run n enabled slots; the masks give expected events and key state per slot index
  task automatic runSlots(input int n, input logic [23:0] onSet, input logic [23:0] offSet,
                          input logic [23:0] konSet);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput(onSet[expSlot], offSet[expSlot], konSet[expSlot]);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expSlot     = 0;
    rst         = 1'b1;
    clk_en      = 1'b0;
    up_keyon    = 1'b0;
    din         = 8'h00;

    // Reset state
    #3;
    checkOutput(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two full laps with no writes
    runSlots(24, 24'd0, 24'd0, 24'd0);
    runSlots(24, 24'd0, 24'd0, 24'd0);

    // All operators of channel 0 on, written together with an enable
    applyStimulus(1'b1, 8'hF0, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(24, CH0_MASK, 24'd0, CH0_MASK);
    runSlots(24, 24'd0, 24'd0, CH0_MASK);

    // Channel 0 off, written during an enable gap
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(24, 24'd0, CH0_MASK, 24'd0);

    // S1 of channel code 5 (index 4) lands on slot 4
    applyStimulus(1'b1, 8'h15, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(24, 24'd1 << 4, 24'd0, 24'd1 << 4);

    // S3 of channel code 2 lands on slot 8
    applyStimulus(1'b1, 8'h42, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(24, 24'd1 << 8, 24'd0, (24'd1 << 4) | (24'd1 << 8));

    // Invalid channel codes 3 and 7 are discarded
    applyStimulus(1'b1, 8'hF3, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hF7, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(24, 24'd0, 24'd0, (24'd1 << 4) | (24'd1 << 8));
    runSlots(24, 24'd0, 24'd0, (24'd1 << 4) | (24'd1 << 8));

    // Gapped write to channel 1, then overwritten by a channel 0 S1 write after slot 7
    applyStimulus(1'b1, 8'hF1, 1'b0);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(2, 24'd1 << 7, 24'd0, (24'd1 << 4) | (24'd1 << 7));
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkOutput(1'b1, 1'b0, 1'b1);
    runSlots(24, 24'd1 << 0, 24'd0, (24'd1 << 0) | (24'd1 << 4) | (24'd1 << 7) | (24'd1 << 8));

    // Coincident write while a write is pending: the entered slot uses the older write
    applyStimulus(1'b1, 8'hF1, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b1);
    runSlots(4, 24'd0, 24'd0, 24'd0);
    applyStimulus(1'b1, 8'h04, 1'b1);
    checkOutput(1'b1, 1'b0, 1'b1);
    runSlots(24, 24'd0, 24'd0,
             (24'd1 << 0) | (24'd1 << 4) | (24'd1 << 7) | (24'd1 << 8) | (24'd1 << 13));

    // Reset mid-cycle with a channel 2 write pending
    applyStimulus(1'b1, 8'hF2, 1'b1);
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(1, 24'd0, 24'd0, 24'd0);
    #2;
    rst = 1'b1;
    #1;
    expSlot = 0;
    checkOutput(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput(1'b0, 1'b0, 1'b0);
    runSlots(24, 24'd0, 24'd0, 24'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
